bpsk_frame_gen: RTL and testbench

Byte-to-bit framer that sits directly upstream of the BPSK mixer in the TX modulator chain and replaces the fixed-pattern test data source. It accepts payload bytes over a valid/ready handshake into a small FIFO. It emits framed bits (preamble, sync word, payload, CRC-8) on a single serial line at a fixed bit rate derived from the system clock. When no frame is pending, it emits idle zeros.

---
 rtl/modem_pkg.sv | 23 ++
 rtl/bpsk_frame_gen_if.sv | 9 +
 rtl/byte_fifo.sv | 56 +++++
 rtl/bpsk_frame_gen.sv | 179 +++++++++++++++++
 tb/tb_bpsk_frame_gen.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/modem_pkg.sv
// Definitions shared across the TX modulator chain: framer state encoding,
// CRC-8 constants and the single-bit CRC update.
package modem_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPreamble = 3'd1,
    StSync     = 3'd2,
    StPayload  = 3'd3,
    StCrc      = 3'd4
  } state_e;

  localparam logic [7:0] CRC8_POLY         = 8'h07;
  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hD3;

  // One MSB-first CRC-8 step for a single transmitted bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/bpsk_frame_gen_if.sv
// Payload byte stream into the framer: valid/ready handshake, push on valid && ready.
interface bpsk_frame_gen_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with registered occupancy count; pushes while full and
// pops while empty are ignored.
module byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         push_i,
  input  logic [7:0]                   data_i,
  input  logic                         pop_i,
  output logic [7:0]                   data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AddrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CountW = $clog2(DEPTH + 1);

  logic [7:0]        mem_q [DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CountW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + CountW'(1);
    if (pop_ok && !push_ok) count_d = count_q - CountW'(1);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= (wr_ptr_q == AddrW'(DEPTH - 1)) ? '0 : wr_ptr_q + AddrW'(1);
      if (pop_ok)  rd_ptr_q <= (rd_ptr_q == AddrW'(DEPTH - 1)) ? '0 : rd_ptr_q + AddrW'(1);
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bpsk_frame_gen.sv
// Byte-to-bit framer feeding the BPSK mixer: preamble, sync word, payload and
// CRC-8 emitted serially at one bit per CLKS_PER_BIT enabled clocks.
module bpsk_frame_gen
  import modem_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 20833,
  parameter int unsigned PREAMBLE_BITS = 16,
  parameter logic [7:0]  SYNC_WORD     = DEFAULT_SYNC_WORD,
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             enable_i,
  bpsk_frame_gen_if.slave  byte_if,
  output logic             data_out_o,
  output logic             bit_strobe_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxMax = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
  localparam int unsigned IdxW   = $clog2(IdxMax + 1);
  localparam int unsigned ByteW  = $clog2(PAYLOAD_BYTES + 1);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);

  logic [TimerW-1:0] timer_q;
  logic              boundary;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [ByteW-1:0]  byte_cnt_q;
  logic [7:0]        shreg_q;
  logic [7:0]        crc_q;
  logic              data_out_q, bit_strobe_q, busy_q, frame_done_q;

  logic [7:0]        fifo_data;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [CountW-1:0] fifo_count;
  logic              frame_ready, idx_done, pre_done, last_byte;

  assign boundary    = enable_i && (timer_q == TimerW'(CLKS_PER_BIT - 1));
  assign frame_ready = (fifo_count >= CountW'(PAYLOAD_BYTES));
  assign idx_done    = (idx_q == IdxW'(8));
  assign pre_done    = (idx_q == IdxW'(PREAMBLE_BITS));
  assign last_byte   = (byte_cnt_q == ByteW'(PAYLOAD_BYTES));

  // A byte leaves the FIFO on the boundary that puts its bit 0 on the line.
  assign fifo_pop = boundary && idx_done && !fifo_empty &&
                    ((state_q == StSync) || ((state_q == StPayload) && !last_byte));

  assign byte_if.byte_ready = !fifo_full;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push_i  (byte_if.byte_valid),
    .data_i  (byte_if.byte_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      timer_q <= '0;
    end else if (enable_i) begin
      timer_q <= boundary ? '0 : timer_q + TimerW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      shreg_q      <= '0;
      crc_q        <= '0;
      data_out_q   <= 1'b0;
      bit_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      bit_strobe_q <= boundary;
      frame_done_q <= 1'b0;
      if (boundary) begin
        // idx_q counts bits already emitted in the current section.
        unique case (state_q)
          StIdle: begin
            if (frame_ready) begin
              state_q    <= StPreamble;
              data_out_q <= 1'b1;
              idx_q      <= IdxW'(1);
              busy_q     <= 1'b1;
              crc_q      <= '0;
            end else begin
              data_out_q <= 1'b0;
            end
          end
          StPreamble: begin
            if (pre_done) begin
              state_q    <= StSync;
              data_out_q <= SYNC_WORD[0];
              idx_q      <= IdxW'(1);
            end else begin
              data_out_q <= ~idx_q[0];
              idx_q      <= idx_q + IdxW'(1);
            end
          end
          StSync: begin
            if (idx_done) begin
              state_q    <= StPayload;
              data_out_q <= fifo_data[0];
              shreg_q    <= {1'b0, fifo_data[7:1]};
              crc_q      <= crc8_step(crc_q, fifo_data[0]);
              idx_q      <= IdxW'(1);
              byte_cnt_q <= ByteW'(1);
            end else begin
              data_out_q <= SYNC_WORD[idx_q[2:0]];
              idx_q      <= idx_q + IdxW'(1);
            end
          end
          StPayload: begin
            if (idx_done && last_byte) begin
              state_q    <= StCrc;
              data_out_q <= crc_q[7];
              idx_q      <= IdxW'(1);
            end else if (idx_done) begin
              data_out_q <= fifo_data[0];
              shreg_q    <= {1'b0, fifo_data[7:1]};
              crc_q      <= crc8_step(crc_q, fifo_data[0]);
              idx_q      <= IdxW'(1);
              byte_cnt_q <= byte_cnt_q + ByteW'(1);
            end else begin
              data_out_q <= shreg_q[0];
              shreg_q    <= {1'b0, shreg_q[7:1]};
              crc_q      <= crc8_step(crc_q, shreg_q[0]);
              idx_q      <= idx_q + IdxW'(1);
            end
          end
          StCrc: begin
            if (idx_done) begin
              frame_done_q <= 1'b1;
              if (frame_ready) begin
                state_q    <= StPreamble;
                data_out_q <= 1'b1;
                idx_q      <= IdxW'(1);
                crc_q      <= '0;
              end else begin
                state_q    <= StIdle;
                data_out_q <= 1'b0;
                busy_q     <= 1'b0;
              end
            end else begin
              data_out_q <= crc_q[3'd7 - idx_q[2:0]];
              idx_q      <= idx_q + IdxW'(1);
            end
          end
          default: begin
            state_q    <= StIdle;
            data_out_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out_o   = data_out_q;
  assign bit_strobe_o = bit_strobe_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_bpsk_frame_gen.sv
// Directed bench for bpsk_frame_gen: three instances cover PAYLOAD_BYTES of 1, 4 and 8.
module tb_bpsk_frame_gen;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  logic en1, en4, en8;
  logic do1, bs1, by1, fd1;
  logic do4, bs4, by4, fd4;
  logic do8, bs8, by8, fd8;

  bpsk_frame_gen_if if1 ();
  bpsk_frame_gen_if if4 ();
  bpsk_frame_gen_if if8 ();

  bpsk_frame_gen #(.CLKS_PER_BIT(4), .PREAMBLE_BITS(8), .SYNC_WORD(8'hD3),
                   .PAYLOAD_BYTES(1), .FIFO_DEPTH(8)) dut1 (
    .clk(clk), .n_reset(n_reset), .enable_i(en1), .byte_if(if1),
    .data_out_o(do1), .bit_strobe_o(bs1), .busy_o(by1), .frame_done_o(fd1));

  bpsk_frame_gen #(.CLKS_PER_BIT(4), .PREAMBLE_BITS(8), .SYNC_WORD(8'hD3),
                   .PAYLOAD_BYTES(4), .FIFO_DEPTH(8)) dut4 (
    .clk(clk), .n_reset(n_reset), .enable_i(en4), .byte_if(if4),
    .data_out_o(do4), .bit_strobe_o(bs4), .busy_o(by4), .frame_done_o(fd4));

  bpsk_frame_gen #(.CLKS_PER_BIT(4), .PREAMBLE_BITS(8), .SYNC_WORD(8'hD3),
                   .PAYLOAD_BYTES(8), .FIFO_DEPTH(8)) dut8 (
    .clk(clk), .n_reset(n_reset), .enable_i(en8), .byte_if(if8),
    .data_out_o(do8), .bit_strobe_o(bs8), .busy_o(by8), .frame_done_o(fd8));

  int checks = 0;
  int errors = 0;

  // Bit-level monitor of the selected instance, sampled on the falling edge.
  int   sel = 0;
  logic qb[$];
  logic qy[$];
  logic qd[$];
  int   ndone = 0;
  int   pops = 0;
  logic m_s, m_d, m_b, m_f, m_p;

  always @(negedge clk) begin
    m_s = 1'b0; m_d = 1'b0; m_b = 1'b0; m_f = 1'b0; m_p = 1'b0;
    case (sel)
      1: begin m_s = bs1; m_d = do1; m_b = by1; m_f = fd1; m_p = dut1.fifo_pop; end
      4: begin m_s = bs4; m_d = do4; m_b = by4; m_f = fd4; m_p = dut4.fifo_pop; end
      8: begin m_s = bs8; m_d = do8; m_b = by8; m_f = fd8; m_p = dut8.fifo_pop; end
      default: ;
    endcase
    if (m_s) begin
      qb.push_back(m_d);
      qy.push_back(m_b);
      qd.push_back(m_f);
      if (m_f) ndone++;
    end
    if (m_p) pops++;
  end

  logic       expq[$];
  logic [7:0] pay[8];

  task automatic clear_mon();
    qb.delete(); qy.delete(); qd.delete();
    ndone = 0;
    pops  = 0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic set_in(input int which, input logic v, input logic [7:0] b);
    case (which)
      1: begin if1.byte_valid = v; if1.byte_in = b; end
      4: begin if4.byte_valid = v; if4.byte_in = b; end
      default: begin if8.byte_valid = v; if8.byte_in = b; end
    endcase
  endtask

  task automatic push(input int which, input logic [7:0] b);
    set_in(which, 1'b1, b);
    @(posedge clk); #1;
    set_in(which, 1'b0, 8'h00);
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && ndone < n; i++) begin
      @(posedge clk); #1;
    end
    if (ndone >= n) ok = 1'b1;
  endtask

  function automatic int find_start();
    for (int i = 0; i < qy.size(); i++) if (qy[i]) return i;
    return -1;
  endfunction

  function automatic int count_busy();
    int n = 0;
    foreach (qy[i]) if (qy[i]) n++;
    return n;
  endfunction

  // Independent reference: preamble, 0xD3 LSB-first, payload LSB-first, CRC MSB-first.
  task automatic add_frame(input int n);
    logic [7:0] c;
    logic [7:0] sw;
    logic       fb, b;
    c  = 8'h00;
    sw = 8'hD3;
    for (int i = 0; i < 8; i++) expq.push_back((i % 2) == 0);
    for (int i = 0; i < 8; i++) expq.push_back(sw[i]);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        b  = pay[k][i];
        expq.push_back(b);
        fb = c[7] ^ b;
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    for (int i = 7; i >= 0; i--) expq.push_back(c[i]);
  endtask

  task automatic load_frame_0x01();
    logic [31:0] e32;
    e32 = 32'b10101010_11001011_10000000_10001001;
    expq.delete();
    for (int i = 0; i < 32; i++) expq.push_back(e32[31 - i]);
  endtask

  task automatic test_reset();
    logic [4:0] got;
    got = {do1, bs1, by1, fd1, if1.byte_ready};
    checks++;
    if (got !== 5'b00001) begin
      errors++; $display("FAIL reset_dut1 got=%b exp=00001", got);
    end
    got = {do4, bs4, by4, fd4, if4.byte_ready};
    checks++;
    if (got !== 5'b00001) begin
      errors++; $display("FAIL reset_dut4 got=%b exp=00001", got);
    end
    got = {do8, bs8, by8, fd8, if8.byte_ready};
    checks++;
    if (got !== 5'b00001) begin
      errors++; $display("FAIL reset_dut8 got=%b exp=00001", got);
    end
    n_reset = 1'b1;
    cycles(3);
    checks++;
    if (bs1 !== 1'b0) begin
      errors++; $display("FAIL first_boundary_early strobe=%b exp=0", bs1);
    end
    cycles(1);
    checks++;
    if ({bs1, do1, by1} !== 3'b100) begin
      errors++; $display("FAIL first_boundary strobe/data/busy=%b exp=100", {bs1, do1, by1});
    end
    cycles(1);
    checks++;
    if (bs1 !== 1'b0) begin
      errors++; $display("FAIL strobe_width strobe=%b exp=0", bs1);
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    int st, bad, nbusy;
    sel = 1; clear_mon();
    push(1, 8'h01);
    wait_done(1, 400, ok);
    cycles(10);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done_timeout ndone=%0d exp=1", ndone); end
    load_frame_0x01();
    st = find_start();
    bad = -1;
    for (int i = 0; i < 32; i++)
      if (bad < 0 && (st < 0 || st + i >= qb.size() || qb[st + i] !== expq[i])) bad = i;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL single_bits first_bad=%0d start=%0d", bad, st); end
    nbusy = count_busy();
    checks++;
    if (nbusy != 32) begin errors++; $display("FAIL single_busy_len got=%0d exp=32", nbusy); end
    checks++;
    if (st < 0 || st + 33 >= qb.size() || ndone != 1 || qd[st + 32] !== 1'b1 ||
        qb[st + 32] !== 1'b0 || qb[st + 33] !== 1'b0) begin
      errors++; $display("FAIL single_done_idle ndone=%0d start=%0d exp done at bit 32 then zeros",
                         ndone, st);
    end
    checks++;
    if (pops != 1) begin errors++; $display("FAIL single_pops got=%0d exp=1", pops); end
  endtask

  task automatic test_zero_payload();
    bit ok;
    int st, bad, nbusy;
    logic [15:0] hdr;
    sel = 4; clear_mon();
    for (int k = 0; k < 4; k++) push(4, 8'h00);
    wait_done(1, 600, ok);
    cycles(10);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_done_timeout ndone=%0d exp=1", ndone); end
    hdr = 16'b10101010_11001011;
    expq.delete();
    for (int i = 0; i < 16; i++) expq.push_back(hdr[15 - i]);
    for (int i = 0; i < 40; i++) expq.push_back(1'b0);
    st = find_start();
    bad = -1;
    for (int i = 0; i < 56; i++)
      if (bad < 0 && (st < 0 || st + i >= qb.size() || qb[st + i] !== expq[i])) bad = i;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL zero_bits first_bad=%0d start=%0d", bad, st); end
    nbusy = count_busy();
    checks++;
    if (nbusy != 56) begin errors++; $display("FAIL zero_frame_len got=%0d exp=56", nbusy); end
    checks++;
    if (pops != 4) begin errors++; $display("FAIL zero_pops got=%0d exp=4", pops); end
  endtask

  task automatic test_fifo_full();
    bit ok, rdy, acc;
    int st, bad, not_ready, pops_at_acc;
    sel = 8; clear_mon();
    not_ready = 0;
    for (int k = 0; k < 8; k++) begin
      pay[k] = 8'h10 + 8'(k * 8'h11);
      if (if8.byte_ready !== 1'b1) not_ready++;
      push(8, pay[k]);
    end
    checks++;
    if (not_ready != 0) begin errors++; $display("FAIL full_ready_early refused=%0d exp=0", not_ready); end
    checks++;
    if (if8.byte_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready_low got=%b exp=0", if8.byte_ready);
    end
    set_in(8, 1'b1, 8'hEE);
    acc = 1'b0;
    pops_at_acc = -1;
    for (int i = 0; i < 300 && !acc; i++) begin
      rdy = if8.byte_ready;
      @(posedge clk); #1;
      if (rdy) begin acc = 1'b1; pops_at_acc = pops; end
    end
    set_in(8, 1'b0, 8'h00);
    checks++;
    if (!acc || pops_at_acc != 1) begin
      errors++; $display("FAIL full_ninth_accept pops_at_accept=%0d exp=1", pops_at_acc);
    end
    wait_done(1, 600, ok);
    cycles(40);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_done_timeout ndone=%0d exp=1", ndone); end
    expq.delete();
    add_frame(8);
    st = find_start();
    bad = -1;
    for (int i = 0; i < 80; i++)
      if (bad < 0 && (st < 0 || st + i >= qb.size() || qb[st + i] !== expq[i])) bad = i;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL full_payload_bits first_bad=%0d start=%0d", bad, st); end
    checks++;
    if (ndone != 1 || by8 !== 1'b0 || if8.byte_ready !== 1'b1) begin
      errors++; $display("FAIL full_after ndone=%0d busy=%b ready=%b exp 1/0/1", ndone, by8,
                         if8.byte_ready);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int st, bad, nbusy;
    sel = 1; clear_mon();
    push(1, 8'h5A);
    push(1, 8'hC3);
    wait_done(2, 800, ok);
    cycles(10);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_done_timeout ndone=%0d exp=2", ndone); end
    expq.delete();
    pay[0] = 8'h5A; add_frame(1);
    pay[0] = 8'hC3; add_frame(1);
    st = find_start();
    bad = -1;
    for (int i = 0; i < 64; i++)
      if (bad < 0 && (st < 0 || st + i >= qb.size() || qb[st + i] !== expq[i])) bad = i;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL b2b_bits first_bad=%0d start=%0d", bad, st); end
    nbusy = count_busy();
    checks++;
    if (nbusy != 64) begin errors++; $display("FAIL b2b_busy_len got=%0d exp=64", nbusy); end
    checks++;
    if (st < 0 || st + 64 >= qd.size() || qd[st + 32] !== 1'b1 || qy[st + 32] !== 1'b1 ||
        qd[st + 64] !== 1'b1 || qy[st + 64] !== 1'b0) begin
      errors++; $display("FAIL b2b_done_pos start=%0d exp done at 32 (busy) and 64 (idle)", st);
    end
  endtask

  task automatic test_enable_hold();
    bit ok;
    int st, bad, bad_hold, nstrobes;
    logic held;
    sel = 1; clear_mon();
    push(1, 8'h01);
    for (int i = 0; i < 400 && count_busy() < 10; i++) cycles(1);
    en1 = 1'b0;
    held = do1;
    nstrobes = qb.size();
    bad_hold = 0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (bs1 !== 1'b0 || do1 !== held || fd1 !== 1'b0) bad_hold++;
    end
    en1 = 1'b1;
    checks++;
    if (bad_hold != 0 || qb.size() != nstrobes || count_busy() < 10) begin
      errors++; $display("FAIL enable_hold bad_cycles=%0d strobes=%0d exp none while disabled",
                         bad_hold, qb.size() - nstrobes);
    end
    wait_done(1, 400, ok);
    cycles(6);
    checks++;
    if (!ok) begin errors++; $display("FAIL enable_done_timeout ndone=%0d exp=1", ndone); end
    load_frame_0x01();
    st = find_start();
    bad = -1;
    for (int i = 0; i < 32; i++)
      if (bad < 0 && (st < 0 || st + i >= qb.size() || qb[st + i] !== expq[i])) bad = i;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL enable_bits first_bad=%0d start=%0d", bad, st); end
  endtask

  task automatic test_reset_mid_payload();
    bit ok;
    int st, bad;
    logic [4:0] got;
    sel = 1; clear_mon();
    push(1, 8'h33);
    push(1, 8'h44);
    for (int i = 0; i < 400 && count_busy() < 20; i++) cycles(1);
    checks++;
    if (by1 !== 1'b1) begin errors++; $display("FAIL rst_mid_not_busy busy=%b exp=1", by1); end
    n_reset = 1'b0;
    #1;
    got = {do1, bs1, by1, fd1, if1.byte_ready};
    checks++;
    if (got !== 5'b00001) begin errors++; $display("FAIL rst_mid_outputs got=%b exp=00001", got); end
    @(posedge clk); #1;
    n_reset = 1'b1;
    clear_mon();
    cycles(60);
    checks++;
    if (count_busy() != 0 || qb.size() == 0) begin
      errors++; $display("FAIL rst_mid_fifo_empty busy_bits=%0d strobes=%0d exp 0 and >0",
                         count_busy(), qb.size());
    end
    clear_mon();
    push(1, 8'h01);
    wait_done(1, 400, ok);
    cycles(6);
    load_frame_0x01();
    st = find_start();
    bad = -1;
    for (int i = 0; i < 32; i++)
      if (bad < 0 && (st < 0 || st + i >= qb.size() || qb[st + i] !== expq[i])) bad = i;
    checks++;
    if (!ok || bad >= 0) begin
      errors++; $display("FAIL rst_next_frame done=%0d first_bad=%0d exp done, no bad bit", ok, bad);
    end
  endtask

  initial begin
    en1 = 1'b1; en4 = 1'b1; en8 = 1'b1;
    set_in(1, 1'b0, 8'h00);
    set_in(4, 1'b0, 8'h00);
    set_in(8, 1'b0, 8'h00);
    @(posedge clk); #1;
    test_reset();
    test_single_frame();
    test_zero_payload();
    test_fifo_full();
    test_back_to_back();
    test_enable_hold();
    test_reset_mid_payload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout time=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
